// File: rtl/seg_scan_if.sv
// Bundle of scan-enable, load and display-drive signals between a host and seg_scan_ctrl.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic                EN;
    logic                LOAD;
    logic [4*NDIG-1:0]   DIN;
    logic                LZS;
    logic [3:0]          code;
    logic                BL_L;
    logic [NDIG-1:0]     dig_L;
    logic                FRAME;
    logic                PENDING;

    modport master (
        output EN, LOAD, DIN, LZS,
        input  code, BL_L, dig_L, FRAME, PENDING
    );

    modport slave (
        input  EN, LOAD, DIN, LZS,
        output code, BL_L, dig_L, FRAME, PENDING
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, NDIG digits, dead time per slot,
// double-buffered display data swapped at frame boundaries or while the scan is stopped.
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic      CLK,
    input  logic      RST_L,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    localparam int DW = 4 * NDIG;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [DW-1:0]   r_disp;
    logic [DW-1:0]   r_pbuf;
    logic            r_pend;
    logic [NDIG-1:0] r_dig_oh;
    logic            r_sup;

    logic            w_slot_end;
    logic            w_frame;
    logic            w_xfer;
    logic [CW-1:0]   w_cnt_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic [DW-1:0]   w_disp_nxt;
    logic [NDIG-1:0] w_hz;
    logic [NDIG-1:0] w_oh_nxt;
    logic            w_sup_nxt;
    logic [3:0]      w_code;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_frame    = bus.EN && w_slot_end && (r_idx == IDX_LAST);
    assign w_xfer     = r_pend && (w_frame || !bus.EN);
    assign w_disp_nxt = w_xfer ? r_pbuf : r_disp;

    always_comb begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (bus.EN) begin
            if (w_slot_end) begin
                w_cnt_nxt = '0;
                w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_idx_nxt = r_idx;
            end
        end
    end

    // w_hz[i]: nibble i and every nibble above it are zero in the next display value
    always_comb begin : zero_scan
        logic acc;
        acc  = 1'b1;
        w_hz = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            acc     = acc & (w_disp_nxt[4*i +: 4] == 4'h0);
            w_hz[i] = acc;
        end
    end

    always_comb begin
        w_oh_nxt = '0;
        for (int i = 0; i < NDIG; i++) begin
            w_oh_nxt[i] = (w_idx_nxt == IW'(i)) && (w_cnt_nxt >= CNT_BLANK);
        end
    end

    assign w_sup_nxt = (w_idx_nxt != '0) && w_hz[w_idx_nxt];

    always_comb begin
        w_code = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_code = r_disp[4*i +: 4];
            end
        end
    end

    // Digit enables and suppression are registered from next-state values so the
    // drivers come straight off flops, only qualified by EN.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_pbuf   <= '0;
            r_pend   <= 1'b0;
            r_dig_oh <= '0;
            r_sup    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_disp   <= w_disp_nxt;
            r_dig_oh <= w_oh_nxt;
            r_sup    <= w_sup_nxt;
            if (bus.LOAD) begin
                r_pbuf <= bus.DIN;
                r_pend <= 1'b1;
            end else if (w_xfer) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign bus.dig_L   = ~(r_dig_oh & {NDIG{bus.EN}});
    assign bus.BL_L    = bus.EN & (|r_dig_oh) & ~(bus.LZS & r_sup);
    assign bus.code    = bus.EN ? w_code : 4'h0;
    assign bus.FRAME   = w_frame;
    assign bus.PENDING = r_pend;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl (NDIG=4, DIV=8, BLANK=2) against a
// time-position reference model of the scan and double buffer.
module tb_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FLEN  = DIV * NDIG;

    logic clk;
    logic rst_l;
    int   n_checks;
    int   n_err;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .CLK   (clk),
        .RST_L (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_t counts enabled cycles since the scan (re)started.
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pbuf;
    logic        m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s t=%0d got=%h want=%h", tag, m_t, got, exp);
        end
    endtask

    task automatic check_outputs();
        int          slot;
        int          c;
        logic [15:0] hi;
        logic [3:0]  e_code;
        logic [3:0]  e_dig;
        logic        e_bl;
        logic        e_frame;
        slot    = (m_t / DIV) % NDIG;
        c       = m_t % DIV;
        hi      = m_disp >> (4 * slot);
        e_code  = 4'h0;
        e_dig   = 4'hF;
        e_bl    = 1'b0;
        e_frame = 1'b0;
        if (bus.EN) begin
            e_code  = hi[3:0];
            e_frame = ((m_t % FLEN) == FLEN - 1);
            if (c >= BLANK) begin
                e_dig = ~(4'b0001 << slot);
                e_bl  = !(bus.LZS && slot > 0 && hi == 16'h0);
            end
        end
        chk("code",    32'(bus.code),    32'(e_code));
        chk("dig_L",   32'(bus.dig_L),   32'(e_dig));
        chk("BL_L",    32'(bus.BL_L),    32'(e_bl));
        chk("FRAME",   32'(bus.FRAME),   32'(e_frame));
        chk("PENDING", 32'(bus.PENDING), 32'(m_pend));
    endtask

    task automatic model_edge();
        logic frame;
        logic xfer;
        frame = bus.EN && ((m_t % FLEN) == FLEN - 1);
        xfer  = m_pend && (frame || !bus.EN);
        if (xfer) m_disp = m_pbuf;
        if (bus.LOAD) begin
            m_pbuf = bus.DIN;
            m_pend = 1'b1;
        end else if (xfer) begin
            m_pend = 1'b0;
        end
        m_t = bus.EN ? m_t + 1 : 0;
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_disp = '0;
        m_pbuf = '0;
        m_pend = 1'b0;
    endtask

    // Inputs are set just after a rising edge; outputs checked at the falling edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] d);
        bus.LOAD = 1'b1;
        bus.DIN  = d;
        step();
        bus.LOAD = 1'b0;
    endtask

    task automatic run_to(input int pos);
        int guard;
        guard = 0;
        while ((m_t % FLEN) != pos && guard < 2 * FLEN) begin
            step();
            guard++;
        end
        chk("run_to_pos", 32'(m_t % FLEN), 32'(pos));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        model_reset();
        rst_l    = 1'b0;
        bus.EN   = 1'b0;
        bus.LOAD = 1'b0;
        bus.DIN  = '0;
        bus.LZS  = 1'b0;
        #2;
        chk("rst_dig_L", 32'(bus.dig_L), 32'hF);
        chk("rst_BL_L",  32'(bus.BL_L),  32'h0);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        steps(3);

        // Load while stopped, then scan two full frames of 1234
        load(16'h1234);
        step();
        chk("disp_after_idle_load", 32'(m_disp), 32'h1234);
        bus.EN = 1'b1;
        steps(2 * FLEN);

        // Double buffer: two loads inside one frame, last one wins at the boundary
        run_to(DIV + 3);
        load(16'h5678);
        run_to(2 * DIV + 1);
        load(16'h9ABC);
        chk("pend_mid_frame", 32'(bus.PENDING), 32'h1);
        run_to(0);
        chk("disp_9abc", 32'(m_disp), 32'h9ABC);
        steps(FLEN);

        // LOAD coincident with FRAME
        run_to(DIV + 2);
        load(16'h1111);
        run_to(FLEN - 1);
        load(16'h2222);
        chk("pend_after_coincident", 32'(bus.PENDING), 32'h1);
        steps(FLEN);
        chk("disp_2222", 32'(m_disp), 32'h2222);
        steps(FLEN);

        // Leading-zero suppression
        bus.LZS = 1'b1;
        bus.EN  = 1'b0;
        load(16'h0050);
        bus.EN  = 1'b1;
        steps(FLEN);
        bus.EN  = 1'b0;
        load(16'h0000);
        bus.EN  = 1'b1;
        steps(FLEN);
        bus.LZS = 1'b0;
        steps(FLEN);

        // EN drop at cnt=5 of slot 1 with a pending load
        bus.DIN = 16'h4321;
        load(16'h4321);
        run_to(DIV + 5);
        bus.EN = 1'b0;
        steps(2);
        chk("disp_after_en_drop", 32'(m_disp), 32'h4321);
        bus.EN = 1'b1;
        steps(FLEN + 4);

        // Asynchronous reset in slot 2 with data pending
        run_to(2 * DIV + 1);
        load(16'h7777);
        rst_l = 1'b0;
        #1;
        model_reset();
        chk("arst_dig_L",   32'(bus.dig_L),   32'hF);
        chk("arst_BL_L",    32'(bus.BL_L),    32'h0);
        chk("arst_code",    32'(bus.code),    32'h0);
        chk("arst_PENDING", 32'(bus.PENDING), 32'h0);
        #1;
        rst_l = 1'b1;
        steps(FLEN);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.EN   = ($urandom_range(0, 19) != 0);
            bus.LOAD = ($urandom_range(0, 9) == 0);
            bus.DIN  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bus.DIN[15:8] = 8'h00;
            bus.LZS  = ($urandom_range(0, 1) == 1);
            step();
        end
        bus.LOAD = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
